// File: rtl/edge_pkg.sv
// Shared mode encoding for the multi-channel edge detector.
package edge_pkg;
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF  = 2'b00;
    localparam mode_t MODE_RISE = 2'b01;
    localparam mode_t MODE_FALL = 2'b10;
    localparam mode_t MODE_BOTH = 2'b11;
endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, stability filter, edge pulses, sticky event flag.
// With EDGE_COUNT_EN defined, also a saturating per-channel event counter.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
`ifdef EDGE_COUNT_EN
    ,
    parameter int CNT_W       = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  mode_t            mode,
    input  logic             evt_clr,
    output logic             level,
    output logic             p_edge,
    output logic             n_edge,
    output logic             evt_flag,
    output logic             flag_nxt
`ifdef EDGE_COUNT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);
    localparam int FC_W = $clog2(FILT_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [FC_W-1:0]        fc;
    logic                   accept;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic                   evt_nxt;

    assign s = sync_q[SYNC_STAGES-1];

    // Pulses and flag are computed from next-state so they land with the level change.
    always_comb begin
        accept   = (s != level) && (fc == FC_LAST);
        rise_nxt = accept & s;
        fall_nxt = accept & ~s;
        evt_nxt  = (rise_nxt & (mode == MODE_RISE || mode == MODE_BOTH)) |
                   (fall_nxt & (mode == MODE_FALL || mode == MODE_BOTH));
        flag_nxt = evt_nxt | (evt_flag & ~evt_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            fc       <= '0;
            level    <= 1'b0;
            p_edge   <= 1'b0;
            n_edge   <= 1'b0;
            evt_flag <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            if (s == level) begin
                fc <= '0;
            end else if (fc == FC_LAST) begin
                level <= s;
                fc    <= '0;
            end else begin
                fc <= fc + 1'b1;
            end
            p_edge   <= rise_nxt;
            n_edge   <= fall_nxt;
            evt_flag <= flag_nxt;
        end
    end

`ifdef EDGE_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (evt_nxt) begin
            if (evt_clr)
                count <= CNT_W'(1);
            else if (!(&count))
                count <= count + 1'b1;
        end else if (evt_clr) begin
            count <= '0;
        end
    end
`endif
endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector with sticky event flags and one irq.
// Define EDGE_COUNT_EN to add saturating per-channel event counters (count port).
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
`ifdef EDGE_COUNT_EN
    ,
    parameter int CNT_W       = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CH-1:0]         din,
    input  logic [2*CH-1:0]       mode,
    input  logic [CH-1:0]         evt_clr,
    output logic [CH-1:0]         level,
    output logic [CH-1:0]         p_edge,
    output logic [CH-1:0]         n_edge,
    output logic [CH-1:0]         evt_flag,
    output logic                  irq
`ifdef EDGE_COUNT_EN
    ,
    output logic [CH*CNT_W-1:0]   count
`endif
);
    logic [CH-1:0] flag_nxt;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_CYCLES(FILT_CYCLES)
`ifdef EDGE_COUNT_EN
            ,
            .CNT_W      (CNT_W)
`endif
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .din     (din[i]),
            .mode    (mode_t'(mode[2*i +: 2])),
            .evt_clr (evt_clr[i]),
            .level   (level[i]),
            .p_edge  (p_edge[i]),
            .n_edge  (n_edge[i]),
            .evt_flag(evt_flag[i]),
            .flag_nxt(flag_nxt[i])
`ifdef EDGE_COUNT_EN
            ,
            .count   (count[i*CNT_W +: CNT_W])
`endif
        );
    end

    // irq tracks the next flag state so it rises in the same cycle as the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            irq <= 1'b0;
        else
            irq <= |flag_nxt;
    end
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed self-checking bench for multi_edge_detector (default parameters).
module tb_multi_edge_detector;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  din;
    logic [15:0] mode;
    logic [7:0]  evt_clr;
    logic [7:0]  level, p_edge, n_edge, evt_flag;
    logic        irq;
`ifdef EDGE_COUNT_EN
    logic [15:0] count;
`endif

    int checks = 0;
    int failures = 0;
    int p_seen, n_seen;

    always #5 clk = ~clk;

    multi_edge_detector #(
        .CH(8), .SYNC_STAGES(2), .FILT_CYCLES(4)
`ifdef EDGE_COUNT_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .mode    (mode),
        .evt_clr (evt_clr),
        .level   (level),
        .p_edge  (p_edge),
        .n_edge  (n_edge),
        .evt_flag(evt_flag),
        .irq     (irq)
`ifdef EDGE_COUNT_EN
        ,
        .count   (count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset   = 1'b0;
        din     = 8'h00;
        mode    = 16'h5555;
        evt_clr = 8'h00;
        tick(2);
        chk("rst_level", {24'd0, level}, 32'd0);
        chk("rst_flag", {24'd0, evt_flag}, 32'd0);
        reset = 1'b1;
        tick(4);
        chk("idle_level", {24'd0, level}, 32'd0);
        chk("idle_pn", {16'd0, p_edge, n_edge}, 32'd0);
        chk("idle_irq", {31'd0, irq}, 32'd0);

        // ch0 clean rise: p_edge exactly at the 6th edge
        din[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("ch0_p_e%0d", k), {31'd0, p_edge[0]}, {31'd0, k == 6});
            chk($sformatf("ch0_lvl_e%0d", k), {31'd0, level[0]}, {31'd0, k >= 6});
            chk($sformatf("ch0_irq_e%0d", k), {31'd0, irq}, {31'd0, k >= 6});
        end
        chk("ch0_flag", {24'd0, evt_flag}, 32'h01);

        // ch1 3-cycle glitch is filtered out
        din[1] = 1'b1;
        tick(3);
        din[1] = 1'b0;
        p_seen = 0;
        n_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (level[1] || p_edge[1] || n_edge[1]) p_seen++;
        end
        chk("ch1_glitch", p_seen, 0);
        chk("ch1_flag", {31'd0, evt_flag[1]}, 32'd0);

        // ch2 falling-only mode
        mode[5:4] = 2'b10;
        din[2] = 1'b1;
        p_seen = 0;
        n_seen = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            p_seen += int'(p_edge[2]);
            n_seen += int'(n_edge[2]);
            if (k == 6) chk("ch2_rise_noflag", {31'd0, evt_flag[2]}, 32'd0);
        end
        din[2] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            p_seen += int'(p_edge[2]);
            n_seen += int'(n_edge[2]);
            if (k == 6) begin
                chk("ch2_fall_n", {31'd0, n_edge[2]}, 32'd1);
                chk("ch2_fall_flag", {31'd0, evt_flag[2]}, 32'd1);
            end
        end
        chk("ch2_p_count", p_seen, 1);
        chk("ch2_n_count", n_seen, 1);
        mode[5:4] = 2'b00;
        tick();
        chk("ch2_mode_keeps_flag", {24'd0, evt_flag}, 32'h05);

        // ch0 fall is not qualified in rise mode; clear coinciding with a rise keeps flag
        din[0] = 1'b0;
        tick(8);
        chk("ch0_fall_level", {31'd0, level[0]}, 32'd0);
        din[0] = 1'b1;
        tick(5);
        evt_clr = 8'h01;
        tick();
        evt_clr = 8'h00;
        chk("ch0_clr_set_p", {31'd0, p_edge[0]}, 32'd1);
        chk("ch0_clr_set_flag", {31'd0, evt_flag[0]}, 32'd1);

        // simultaneous rises on ch5..7
        din[7:5] = 3'b111;
        tick(6);
        chk("multi_p", {24'd0, p_edge}, 32'he0);
        chk("multi_flag", {24'd0, evt_flag}, 32'he5);
        tick();
        chk("multi_p_off", {24'd0, p_edge}, 32'h00);

        evt_clr = 8'hff;
        tick();
        evt_clr = 8'h00;
        chk("clr_flag", {24'd0, evt_flag}, 32'h00);
        chk("clr_irq", {31'd0, irq}, 32'd0);
        tick();
        chk("clr_hold", {23'd0, irq, evt_flag}, 32'd0);

`ifdef EDGE_COUNT_EN
        for (int r = 1; r <= 5; r++) begin
            din[3] = 1'b1;
            tick(8);
            chk($sformatf("cnt_rise%0d", r), {30'd0, count[7:6]}, (r > 3) ? 32'd3 : r);
            din[3] = 1'b0;
            tick(8);
        end
        din[3] = 1'b1;
        tick(5);
        evt_clr = 8'h08;
        tick();
        evt_clr = 8'h00;
        chk("cnt_clr_evt", {30'd0, count[7:6]}, 32'd1);
        evt_clr = 8'h08;
        tick();
        evt_clr = 8'h00;
        chk("cnt_clr", {30'd0, count[7:6]}, 32'd0);
`endif

        // reset mid-filter on ch4
        din[4] = 1'b1;
        tick(3);
        reset = 1'b0;
        #1;
        chk("arst_level", {24'd0, level}, 32'd0);
        chk("arst_flag_irq", {23'd0, irq, evt_flag}, 32'd0);
`ifdef EDGE_COUNT_EN
        chk("arst_count", {16'd0, count}, 32'd0);
`endif
        tick();
        chk("arst_hold", {8'd0, level, p_edge, n_edge}, 32'd0);
        din = 8'h10;
        tick();
        reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("rel_p_e%0d", k), {24'd0, p_edge}, (k == 6) ? 32'h10 : 32'h00);
        end
        chk("rel_flag", {24'd0, evt_flag}, 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
